// File: rtl/pal_pkg.sv
// pal_pkg: definitions shared by the PAL configuration blocks.
// Holds the loader state encoding and a small width helper for counters.
package pal_pkg;

    // Loader sequencing states; 2-bit encoding shared with other PAL config blocks.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } pal_cfg_state_e;

    // Number of bits needed to represent 0..value-1 (never less than 1).
    function automatic int pal_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/pal_cfg_shreg.sv
// pal_cfg_shreg: shadow shift register for the PAL config loader.
// Bits enter at the MSB and move toward bit 0, so the first bit shifted in
// ends up in data_o[0] after WIDTH shifts. WIDTH must be at least 2.
module pal_cfg_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // Shift one serial bit in from the top whenever the loader accepts a data bit.
    // NOTE: the shadow is an ordinary flop array, so it is reset like any other state;
    // a commit can then never expose undefined contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            // NOTE: non-blocking so the right-hand side uses pre-edge values regardless of statement order.
            data_q <= {bit_i, data_q[WIDTH-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pal_config_loader.sv
// pal_config_loader: serial configuration loader for the PAL fabric.
// A bitstream is shifted into a shadow register and committed atomically to
// cfg_out; partial or aborted loads leave cfg_out and cfg_loaded untouched.
// Optional feature: define PAL_CFG_PARITY_EN to expect one trailing even-parity
// bit per load; a parity error skips the commit and sets the sticky cfg_err.
module pal_config_loader
    import pal_pkg::*;
#(
    parameter int CFG_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic               cfg_valid,
    input  logic               cfg_bit,
    output logic [CFG_LEN-1:0] cfg_out,
    output logic               cfg_loaded,
    output logic               busy,
    output logic               cfg_err
);

`ifdef PAL_CFG_PARITY_EN
    localparam int N = CFG_LEN + 1;
`else
    localparam int N = CFG_LEN;
`endif

    // Bits per load (data plus optional parity) and data bits, at counter width.
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CFG_LEN);

    pal_cfg_state_e     state_q;
    logic [CNT_W-1:0]   count_q;
    logic               en_prev_q;
    logic [CFG_LEN-1:0] cfg_out_q;
    logic               loaded_q;
    logic [CFG_LEN-1:0] shadow;
    logic               load_start;
    logic               accept;
    logic               shift_en;

    // A load starts only on a 0->1 transition of cfg_en observed while idle.
    assign load_start = (state_q == ST_IDLE) && cfg_en && !en_prev_q;

    // A bit is taken while the count is short of N. Dropping cfg_en aborts, except
    // when the dropped cycle carries the final bit: completion wins over abort.
    assign accept = (state_q == ST_LOAD) && cfg_valid && (count_q != N_CNT) &&
                    (cfg_en || (count_q == N_CNT - CNT_W'(1)));

    // Only data bits enter the shadow; a trailing parity bit is merely accumulated.
    assign shift_en = accept && (count_q < LEN_CNT);

    pal_cfg_shreg #(
        .WIDTH(CFG_LEN)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en),
        .bit_i      (cfg_bit),
        .data_o     (shadow)
    );

`ifdef PAL_CFG_PARITY_EN
    logic par_q;
    logic err_q;
`endif

    // Loader FSM: edge detect, bit counting, optional parity check and atomic commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            en_prev_q <= 1'b0;
            cfg_out_q <= '0;
            loaded_q  <= 1'b0;
`ifdef PAL_CFG_PARITY_EN
            par_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            en_prev_q <= cfg_en;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        count_q <= '0;
`ifdef PAL_CFG_PARITY_EN
                        par_q   <= 1'b0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (count_q == N_CNT) begin
`ifdef PAL_CFG_PARITY_EN
                        if (par_q) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_COMMIT;
                        end
`else
                        state_q <= ST_COMMIT;
`endif
                    end else if (accept) begin
                        count_q <= count_q + CNT_W'(1);
`ifdef PAL_CFG_PARITY_EN
                        par_q   <= par_q ^ cfg_bit;
`endif
                    end else if (!cfg_en) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    cfg_out_q <= shadow;
                    loaded_q  <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    if (!cfg_en) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_out    = cfg_out_q;
    assign cfg_loaded = loaded_q;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
`ifdef PAL_CFG_PARITY_EN
    assign cfg_err    = err_q;
`else
    assign cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pal_config_loader.sv
// tb_pal_config_loader: directed and randomized checks of pal_config_loader
// (CFG_LEN=8) against a word-level reference model kept in the bench.
module tb_pal_config_loader;

    localparam int CFG_LEN = 8;
    localparam int CNT_W   = 5;
`ifdef PAL_CFG_PARITY_EN
    localparam int N_BITS = CFG_LEN + 1;
`else
    localparam int N_BITS = CFG_LEN;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_en;
    logic               cfg_valid;
    logic               cfg_bit;
    logic [CFG_LEN-1:0] cfg_out;
    logic               cfg_loaded;
    logic               busy;
    logic               cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state and the serial stream of the current load.
    logic [CFG_LEN-1:0] exp_out;
    logic               exp_loaded;
    logic               exp_err;
    logic               stream[$];

    always #5 clk = ~clk;

    pal_config_loader #(
        .CFG_LEN(CFG_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_out    (cfg_out),
        .cfg_loaded (cfg_loaded),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    // ---------------- model helpers ----------------
    function automatic logic [CFG_LEN-1:0] model_word();
        logic [CFG_LEN-1:0] w;
        w = '0;
        for (int i = 0; i < CFG_LEN; i++) w[i] = stream[i];
        return w;
    endfunction

    function automatic logic model_parity_bad();
        logic p;
        p = 1'b0;
        for (int i = 0; i < N_BITS; i++) p ^= stream[i];
        return p;
    endfunction

    task automatic make_stream(input logic [CFG_LEN-1:0] word);
        stream.delete();
        for (int i = 0; i < CFG_LEN; i++) stream.push_back(word[i]);
    endtask

`ifdef PAL_CFG_PARITY_EN
    task automatic add_parity(input logic corrupt);
        logic p;
        p = 1'b0;
        for (int i = 0; i < CFG_LEN; i++) p ^= stream[i];
        stream.push_back(p ^ corrupt);
    endtask
`endif

    // ---------------- drive helpers ----------------
    task automatic start_load();
        @(negedge clk);
        cfg_en    = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clk);
    endtask

    // Send the stream; optionally stall before bits and drop cfg_en with the final bit.
    task automatic run_stream(input int stall_pct, input logic drop_last);
        for (int i = 0; i < stream.size(); i++) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                @(negedge clk);
                cfg_valid = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_bit   = stream[i];
            if (drop_last && i == N_BITS - 1) cfg_en = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic finish_load();
        @(negedge clk);
        cfg_en    = 1'b0;
        cfg_valid = 1'b0;
        @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; cfg_en = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (cfg_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 00", cfg_out); end
        n_tests++; if (cfg_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded: got %b want 0", cfg_loaded); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        rst_n = 1'b1;
        exp_out = '0; exp_loaded = 1'b0; exp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        make_stream(8'h4D);
`ifdef PAL_CFG_PARITY_EN
        add_parity(1'b0);
`endif
        start_load();
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_load: got %b want 1", busy); end
        run_stream(0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_commit: got %b want 1", busy); end
        n_tests++; if (cfg_out !== exp_out) begin n_fail++; $display("FAIL basic_early: got %h want %h", cfg_out, exp_out); end
        @(posedge clk);
        @(negedge clk);
        exp_out = model_word(); exp_loaded = 1'b1;
        n_tests++; if (cfg_out !== 8'h4D) begin n_fail++; $display("FAIL basic_out: got %h want 4d", cfg_out); end
        n_tests++; if (cfg_loaded !== 1'b1) begin n_fail++; $display("FAIL basic_loaded: got %b want 1", cfg_loaded); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        finish_load();
    endtask

    task automatic test_abort();
        make_stream(8'hB6);
        stream = stream[0:4];
        start_load();
        run_stream(0, 1'b0);
        cfg_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (cfg_out !== exp_out) begin n_fail++; $display("FAIL abort_out: got %h want %h", cfg_out, exp_out); end
        n_tests++; if (cfg_loaded !== 1'b1) begin n_fail++; $display("FAIL abort_loaded: got %b want 1", cfg_loaded); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_midload();
        make_stream(8'h00);
        stream = stream[0:2];
        start_load();
        run_stream(0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++; if (cfg_out !== '0) begin n_fail++; $display("FAIL midrst_out: got %h want 00", cfg_out); end
        n_tests++; if (cfg_loaded !== 1'b0) begin n_fail++; $display("FAIL midrst_loaded: got %b want 0", cfg_loaded); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1; cfg_en = 1'b0;
        exp_out = '0; exp_loaded = 1'b0; exp_err = 1'b0;
        make_stream(8'hA5);
`ifdef PAL_CFG_PARITY_EN
        add_parity(1'b0);
`endif
        start_load();
        run_stream(0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_out = model_word(); exp_loaded = 1'b1;
        n_tests++; if (cfg_out !== 8'hA5) begin n_fail++; $display("FAIL midrst_reload: got %h want a5", cfg_out); end
        n_tests++; if (cfg_loaded !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_loaded: got %b want 1", cfg_loaded); end
        finish_load();
    endtask

    task automatic test_stall();
        make_stream(8'h4D);
`ifdef PAL_CFG_PARITY_EN
        add_parity(1'b0);
`endif
        start_load();
        run_stream(100, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_out = model_word();
        n_tests++; if (cfg_out !== 8'h4D) begin n_fail++; $display("FAIL stall_out: got %h want 4d", cfg_out); end
        finish_load();
    endtask

    task automatic test_overrun();
        make_stream(8'h3C);
`ifdef PAL_CFG_PARITY_EN
        add_parity(1'b0);
`endif
        stream.push_back(1'b1);
        stream.push_back(1'b1);
        start_load();
        run_stream(0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_out = model_word();
        n_tests++; if (cfg_out !== 8'h3C) begin n_fail++; $display("FAIL overrun_out: got %h want 3c", cfg_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_busy: got %b want 0", busy); end
        finish_load();
    endtask

`ifdef PAL_CFG_PARITY_EN
    task automatic test_parity();
        make_stream(8'h4D);
        add_parity(1'b0);
        start_load();
        run_stream(0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_out = 8'h4D;
        n_tests++; if (cfg_out !== 8'h4D) begin n_fail++; $display("FAIL par_good_out: got %h want 4d", cfg_out); end
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL par_good_err: got %b want 0", cfg_err); end
        finish_load();
        make_stream(8'hA5);
        add_parity(1'b1);
        start_load();
        run_stream(0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_err: got %b want 1", cfg_err); end
        n_tests++; if (cfg_out !== 8'h4D) begin n_fail++; $display("FAIL par_bad_out: got %h want 4d", cfg_out); end
        n_tests++; if (cfg_loaded !== 1'b1) begin n_fail++; $display("FAIL par_bad_loaded: got %b want 1", cfg_loaded); end
        finish_load();
        start_load();
        @(negedge clk);
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL par_err_clear: got %b want 0", cfg_err); end
        cfg_en = 1'b0;
        @(posedge clk);
        exp_err = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [CFG_LEN-1:0] word;
            int abort_at;
            logic drop_last;
            word = CFG_LEN'($urandom);
            make_stream(word);
`ifdef PAL_CFG_PARITY_EN
            add_parity(1'($urandom_range(3) == 0));
`endif
            abort_at  = ($urandom_range(3) == 0) ? int'($urandom_range(N_BITS - 1)) : -1;
            drop_last = (abort_at < 0) && (it % 4 == 1);
            if (abort_at >= 0) begin
                while (stream.size() > abort_at) void'(stream.pop_back());
            end else if (!drop_last) begin
                repeat ($urandom_range(2)) stream.push_back(1'($urandom_range(1)));
            end
            // Word-level prediction of the load outcome.
            if (abort_at < 0) begin
`ifdef PAL_CFG_PARITY_EN
                exp_err = model_parity_bad();
`else
                exp_err = 1'b0;
`endif
                if (!exp_err) begin
                    exp_out    = model_word();
                    exp_loaded = 1'b1;
                end
            end else begin
                exp_err = 1'b0;
            end
            start_load();
            run_stream(30, drop_last);
            if (abort_at >= 0) cfg_en = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            n_tests++; if (cfg_out !== exp_out) begin n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", it, cfg_out, exp_out); end
            n_tests++; if (cfg_loaded !== exp_loaded) begin n_fail++; $display("FAIL rand_loaded[%0d]: got %b want %b", it, cfg_loaded, exp_loaded); end
            n_tests++; if (cfg_err !== exp_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", it, cfg_err, exp_err); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b want 0", it, busy); end
            finish_load();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_reset_midload();
        test_stall();
        test_overrun();
`ifdef PAL_CFG_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so a stuck run still terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
